// File: rtl/cnn_ecg_window_sequencer_if.sv
// Sample stream, classifier hookup and result handshake of the ECG window sequencer.
// master = sequencer side, slave = surrounding stream source / classifier / consumer.
interface cnn_ecg_window_sequencer_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WIN      = 32,
  parameter int unsigned CLASS_W  = 8
);
  logic                    flush;
  logic                    s_valid;
  logic                    s_ready;
  logic [SAMPLE_W-1:0]     s_data;
  logic [WIN*SAMPLE_W-1:0] win_flat;
  logic [CLASS_W-1:0]      cnn_class;
  logic                    m_valid;
  logic                    m_ready;
  logic [CLASS_W-1:0]      m_class;
  logic [15:0]             m_seq;
  logic                    alert;
  logic                    busy;

  modport master (
    input  flush, s_valid, s_data, cnn_class, m_ready,
    output s_ready, win_flat, m_valid, m_class, m_seq, alert, busy
  );

  modport slave (
    output flush, s_valid, s_data, cnn_class, m_ready,
    input  s_ready, win_flat, m_valid, m_class, m_seq, alert, busy
  );
endinterface

// File: rtl/cnn_ecg_window_sequencer.sv
// Builds a sliding sample window for the combinational CNN ECG classifier, holds it
// stable for a settle time, then captures the class flags into a valid/ready result.
module cnn_ecg_window_sequencer #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned WIN      = 32,
  parameter int unsigned HOP      = 8,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned CLASS_W  = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  cnn_ecg_window_sequencer_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(WIN + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE + 1);
  localparam int unsigned SEQ_W  = 16;
  localparam int unsigned FLAT_W = WIN * SAMPLE_W;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2,
    ST_HOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [FLAT_W-1:0]   win_q, win_d;
  logic                m_valid_q, m_valid_d;
  logic [CLASS_W-1:0]  m_class_q, m_class_d;
  logic [SEQ_W-1:0]    m_seq_q, m_seq_d;
  logic                alert_q, alert_d;

  logic                s_ready_c;
  logic                accept_c;
  logic [CNT_W-1:0]    last_c;

  assign s_ready_c = (state_q == ST_FILL) || (state_q == ST_HOP);
  assign accept_c  = bus.s_valid && s_ready_c;
  assign last_c    = (state_q == ST_FILL) ? CNT_W'(WIN - 1) : CNT_W'(HOP - 1);

  // Next-state and datapath: flush wins over every other transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    win_d     = win_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    m_seq_d   = m_seq_q;
    alert_d   = 1'b0;

    if (bus.flush) begin
      state_d   = ST_FILL;
      cnt_d     = '0;
      settle_d  = '0;
      win_d     = '0;
      m_valid_d = 1'b0;
      m_seq_d   = '0;
    end else begin
      // Oldest sample sits in slot 0 (LSBs); the newest enters the top slot.
      if (accept_c) begin
        win_d = {bus.s_data, win_q[FLAT_W-1:SAMPLE_W]};
      end

      case (state_q)
        ST_FILL, ST_HOP: begin
          if (accept_c) begin
            if (cnt_q == last_c) begin
              state_d  = ST_EVAL;
              cnt_d    = '0;
              settle_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_EVAL: begin
          if (settle_q == SET_W'(SETTLE - 1)) begin
            state_d   = ST_OUT;
            m_class_d = bus.cnn_class;
            m_valid_d = 1'b1;
            alert_d   = ~bus.cnn_class[0];
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        ST_OUT: begin
          if (m_valid_q && bus.m_ready) begin
            state_d   = ST_HOP;
            m_valid_d = 1'b0;
            m_seq_d   = m_seq_q + SEQ_W'(1);
            cnt_d     = '0;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      settle_q  <= '0;
      win_q     <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      m_seq_q   <= '0;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      win_q     <= win_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      m_seq_q   <= m_seq_d;
      alert_q   <= alert_d;
    end
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.busy     = (state_q == ST_EVAL) || (state_q == ST_OUT);
  assign bus.win_flat = win_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_class  = m_class_q;
  assign bus.m_seq    = m_seq_q;
  assign bus.alert    = alert_q;

endmodule

// File: tb/tb_cnn_ecg_window_sequencer.sv
// Bench for the ECG window sequencer: directed scenarios plus random streaming, all
// outputs compared every cycle against a sample-queue model of the sequencing rules.
module tb_cnn_ecg_window_sequencer;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned WIN      = 32;
  localparam int unsigned HOP      = 8;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned CLASS_W  = 8;
  localparam int unsigned FLAT_W   = WIN * SAMPLE_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cnn_ecg_window_sequencer_if #(.SAMPLE_W(SAMPLE_W), .WIN(WIN), .CLASS_W(CLASS_W)) bus ();

  cnn_ecg_window_sequencer #(
    .SAMPLE_W(SAMPLE_W), .WIN(WIN), .HOP(HOP), .SETTLE(SETTLE), .CLASS_W(CLASS_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stand-in classifier: a scrambled fold of the whole window, or a forced value.
  logic               cls_force_en = 1'b0;
  logic [CLASS_W-1:0] cls_force    = '0;

  function automatic logic [7:0] fake_cls(input logic [FLAT_W-1:0] w);
    logic [7:0] acc;
    acc = 8'h5A;
    for (int i = 0; i < WIN; i++) begin
      acc = {acc[6:0], acc[7]} ^ w[i*SAMPLE_W +: 8] ^ w[i*SAMPLE_W+8 +: 8];
    end
    return acc;
  endfunction

  always_comb bus.cnn_class = cls_force_en ? cls_force : fake_cls(bus.win_flat);

  // Behavioural model: window as a list of the last WIN samples, plus how many samples
  // are still needed, how many settle cycles remain, and the pending result.
  logic [SAMPLE_W-1:0] mwin [WIN];
  int                  need;
  int                  eval_left;
  bit                  mv;
  bit                  malert;
  logic [CLASS_W-1:0]  mclass;
  logic [15:0]         mseq;
  logic [CLASS_W-1:0]  mcls;

  function automatic logic [FLAT_W-1:0] flat(input logic [SAMPLE_W-1:0] a [WIN]);
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < WIN; i++) f[i*SAMPLE_W +: SAMPLE_W] = a[i];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) mwin[i] = '0;
      need = WIN; eval_left = 0; mv = 1'b0; malert = 1'b0; mclass = '0; mseq = '0;
    end else begin
      mcls   = cls_force_en ? cls_force : fake_cls(flat(mwin));
      malert = 1'b0;
      if (bus.flush) begin
        for (int i = 0; i < WIN; i++) mwin[i] = '0;
        need = WIN; eval_left = 0; mv = 1'b0; mseq = '0;
      end else if (mv) begin
        if (bus.m_ready) begin
          mv = 1'b0; mseq = mseq + 16'd1; need = HOP;
        end
      end else if (eval_left > 0) begin
        eval_left--;
        if (eval_left == 0) begin
          mclass = mcls; mv = 1'b1; malert = !mcls[0];
        end
      end else if (bus.s_valid) begin
        for (int i = 0; i < WIN - 1; i++) mwin[i] = mwin[i+1];
        mwin[WIN-1] = bus.s_data;
        need--;
        if (need == 0) eval_left = SETTLE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [FLAT_W-1:0] act,
                       input logic [FLAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_ready", 32'(bus.s_ready), 32'(!mv && eval_left == 0));
      chk("busy", 32'(bus.busy), 32'(mv || eval_left > 0));
      chk("m_valid", 32'(bus.m_valid), 32'(mv));
      chk("m_class", 32'(bus.m_class), 32'(mclass));
      chk("m_seq", 32'(bus.m_seq), 32'(mseq));
      chk("alert", 32'(bus.alert), 32'(malert));
      chk_w("win_flat", bus.win_flat, flat(mwin));
    end
  end

  // Independent monitors of what the DUT actually consumed and signalled.
  int dut_acc   = 0;
  int alert_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && !bus.flush && bus.s_valid && bus.s_ready) dut_acc++;
  end
  always @(negedge clk) begin
    if (bus.alert) alert_cnt++;
  end

  bit rnd_mready = 1'b0;
  always @(posedge clk) begin
    if (rnd_mready) begin
      #1;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer d (after gap idle cycles) until accepted; returns just after the accepting edge.
  task automatic push(input logic [15:0] d, input int gap);
    int n = 0;
    if (gap > 0) begin
      bus.s_valid = 1'b0;
      repeat (gap) begin
        bus.s_data = 16'($urandom);
        step();
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.s_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: s_ready stayed 0 for %0d cycles at %0t", n, $time);
    end
    step();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.m_valid && n < budget) begin
      step();
      n++;
    end
    if (!bus.m_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: no m_valid within %0d cycles at %0t", budget, $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [FLAT_W-1:0] ramp;
  int                acc1, acc2;

  initial begin
    rst_n = 1'b1;
    bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk_w("rst_window", bus.win_flat, '0);
    #2 rst_n = 1'b1;
    step();

    // Fill with a ramp; result appears the cycle after the second settle edge.
    for (int i = 0; i < WIN; i++) push(16'(i), 0);
    bus.s_valid = 1'b0;
    for (int i = 0; i < WIN; i++) ramp[i*SAMPLE_W +: SAMPLE_W] = 16'(i);
    chk_w("fill_window", bus.win_flat, ramp);
    chk("fill_eval_busy", 32'(bus.busy), 32'd1);
    step();
    chk("fill_settle1_valid", 32'(bus.m_valid), 32'd0);
    step();
    chk("fill_result_valid", 32'(bus.m_valid), 32'd1);
    chk("fill_result_class", 32'(bus.m_class), 32'(fake_cls(ramp)));
    chk("fill_result_seq", 32'(bus.m_seq), 32'd0);
    acc1 = dut_acc;
    step();

    // Hop by eight samples.
    for (int i = 0; i < HOP; i++) push(16'(WIN + i), 0);
    bus.s_valid = 1'b0;
    chk("hop_slot0", 32'(bus.win_flat[0 +: SAMPLE_W]), 32'd8);
    chk("hop_slot31", 32'(bus.win_flat[(WIN-1)*SAMPLE_W +: SAMPLE_W]), 32'd39);
    wait_valid(20);
    acc2 = dut_acc;
    chk("hop_seq", 32'(bus.m_seq), 32'd1);
    chk("hop_accepts", 32'(acc2 - acc1), 32'(HOP));
    step();

    // Backpressure: result held, input stalled while the consumer is not ready.
    bus.m_ready = 1'b0;
    for (int i = 0; i < HOP; i++) push(16'(40 + i), 0);
    wait_valid(20);
    bus.s_valid = 1'b1; bus.s_data = 16'hAAAA;
    acc1 = dut_acc;
    repeat (20) begin
      step();
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
      chk("bp_m_seq", 32'(bus.m_seq), 32'd2);
    end
    chk("bp_no_consume", 32'(dut_acc - acc1), 32'd0);
    bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    chk("bp_released_valid", 32'(bus.m_valid), 32'd0);
    chk("bp_hop_resumes", 32'(bus.s_ready), 32'd1);

    // Signed sample passthrough and alert on a non-Normal class.
    cls_force_en = 1'b1; cls_force = 8'h02;
    alert_cnt = 0;
    for (int i = 0; i < HOP - 1; i++) push(16'($urandom), 0);
    push(16'hFFFB, 0);
    bus.s_valid = 1'b0;
    chk("signed_slot", 32'(bus.win_flat[(WIN-1)*SAMPLE_W +: SAMPLE_W]), 32'h0000FFFB);
    wait_valid(20);
    repeat (3) step();
    chk("alert_once", 32'(alert_cnt), 32'd1);
    cls_force = 8'h01;
    alert_cnt = 0;
    for (int i = 0; i < HOP; i++) push(16'($urandom), 1);
    bus.s_valid = 1'b0;
    wait_valid(20);
    repeat (3) step();
    chk("alert_none", 32'(alert_cnt), 32'd0);
    cls_force_en = 1'b0;

    // Flush mid-hop: window cleared, sequence restarts, a full window needed again.
    for (int i = 0; i < 4; i++) push(16'($urandom), 0);
    bus.flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'h1234;
    step();
    bus.flush = 1'b0; bus.s_valid = 1'b0;
    chk("flush_seq", 32'(bus.m_seq), 32'd0);
    chk_w("flush_window", bus.win_flat, '0);
    chk("flush_s_ready", 32'(bus.s_ready), 32'd1);
    for (int i = 0; i < WIN - 1; i++) push(16'($urandom), int'($urandom_range(0, 2)));
    bus.s_valid = 1'b0;
    repeat (6) begin
      step();
      chk("flush_no_early_valid", 32'(bus.m_valid), 32'd0);
    end
    push(16'($urandom), 0);
    bus.s_valid = 1'b0;
    wait_valid(20);
    chk("flush_first_seq", 32'(bus.m_seq), 32'd0);
    step();

    // Random streaming with random consumer readiness and occasional flushes.
    rnd_mready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        bus.flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'($urandom);
        step();
        bus.flush = 1'b0;
      end
      push(16'($urandom), int'($urandom_range(0, 2)));
    end
    bus.s_valid = 1'b0;
    rnd_mready = 1'b0;
    repeat (2) step();
    bus.m_ready = 1'b1;

    // Asynchronous reset while evaluating.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < WIN; i++) push(16'($urandom), 0);
    bus.s_valid = 1'b0;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_m_seq", 32'(bus.m_seq), 32'd0);
    chk("arst_alert", 32'(bus.alert), 32'd0);
    chk_w("arst_window", bus.win_flat, '0);
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    chk("post_reset_s_ready", 32'(bus.s_ready), 32'd1);
    for (int i = 0; i < WIN; i++) push(16'($urandom), 0);
    bus.s_valid = 1'b0;
    wait_valid(20);
    chk("post_reset_seq", 32'(bus.m_seq), 32'd0);
    repeat (3) step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
